// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// game_sequencer : per-frame IDLE/PLAY/OVER controller for player and obstacle
// Revision: 1.0
// ============================================================================
module game_sequencer #(
  parameter int         SCREEN_W      = 640,
  parameter int         SCREEN_H      = 480,
  parameter int         BOX_WIDTH     = 30,
  parameter int         BOX_HEIGHT    = 30,
  parameter int         BOX_Y_START   = 315,
  parameter int         PLAYER_X_INIT = 305,
  parameter int         PLAYER_STEP   = 4,
  parameter int         OBS_W         = 40,
  parameter int         OBS_H         = 20,
  parameter int         OBS_SPEED     = 3,
  parameter logic [9:0] LFSR_SEED     = 10'h1A5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_start,
  output logic [9:0]  player_x,
  output logic [9:0]  obstacle_x,
  output logic [9:0]  obstacle_y,
  output logic [9:0]  obstacle_width,
  output logic [9:0]  obstacle_height,
  output logic [15:0] score,
  output logic        game_over,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  localparam logic [10:0] C_SPAWN_LIM  = 11'(SCREEN_W - OBS_W);
  localparam logic [10:0] C_PLAYER_MAX = 11'(SCREEN_W - BOX_WIDTH);
  localparam logic [10:0] C_STEP       = 11'(PLAYER_STEP);
  localparam logic [10:0] C_BOX_W      = 11'(BOX_WIDTH);
  localparam logic [10:0] C_BOX_Y      = 11'(BOX_Y_START);
  localparam logic [10:0] C_BOX_Y_END  = 11'(BOX_Y_START + BOX_HEIGHT);
  localparam logic [10:0] C_OBS_W      = 11'(OBS_W);
  localparam logic [10:0] C_OBS_H      = 11'(OBS_H);
  localparam logic [10:0] C_OBS_SPEED  = 11'(OBS_SPEED);
  localparam logic [10:0] C_SCREEN_H   = 11'(SCREEN_H);
  localparam logic [9:0]  C_PLAYER_INIT = 10'(PLAYER_X_INIT);

  state_t      r_state;
  logic [9:0]  r_lfsr;
  logic        r_start_prev;

  logic        w_start_edge;
  logic [10:0] w_lfsr_ext;
  logic [9:0]  w_spawn_x;
  logic [10:0] w_px;
  logic [10:0] w_ox;
  logic [10:0] w_oy;
  logic        w_hit;
  logic [9:0]  w_player_next;
  logic [10:0] w_y_next;

  assign state        = r_state;
  assign w_start_edge = btn_start & ~r_start_prev;

  // Folding the top of the LFSR range back keeps the obstacle fully on screen.
  assign w_lfsr_ext = {1'b0, r_lfsr};
  assign w_spawn_x  = (w_lfsr_ext > C_SPAWN_LIM) ? 10'(w_lfsr_ext - C_SPAWN_LIM) : r_lfsr;

  assign w_px     = {1'b0, player_x};
  assign w_ox     = {1'b0, obstacle_x};
  assign w_oy     = {1'b0, obstacle_y};
  assign w_y_next = w_oy + C_OBS_SPEED;

  assign w_hit = (w_px < w_ox + C_OBS_W) && (w_ox < w_px + C_BOX_W) &&
                 (C_BOX_Y < w_oy + C_OBS_H) && (w_oy < C_BOX_Y_END);

  always_comb begin
    w_player_next = player_x;
    if (btn_left && !btn_right) begin
      w_player_next = (w_px < C_STEP) ? 10'd0 : 10'(w_px - C_STEP);
    end else if (btn_right && !btn_left) begin
      w_player_next = (w_px + C_STEP > C_PLAYER_MAX) ? 10'(C_PLAYER_MAX) : 10'(w_px + C_STEP);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_lfsr          <= LFSR_SEED;
      r_start_prev    <= 1'b0;
      player_x        <= C_PLAYER_INIT;
      obstacle_x      <= 10'd0;
      obstacle_y      <= 10'd0;
      obstacle_width  <= 10'd0;
      obstacle_height <= 10'd0;
      score           <= 16'd0;
      game_over       <= 1'b0;
    end else begin
      r_lfsr       <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
      r_start_prev <= btn_start;
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_state         <= S_PLAY;
            player_x        <= C_PLAYER_INIT;
            obstacle_x      <= w_spawn_x;
            obstacle_y      <= 10'd0;
            obstacle_width  <= 10'(OBS_W);
            obstacle_height <= 10'(OBS_H);
            score           <= 16'd0;
          end
        end
        S_PLAY: begin
          if (frame_tick) begin
            if (w_hit) begin
              r_state   <= S_OVER;
              game_over <= 1'b1;
            end else begin
              player_x <= w_player_next;
              if (w_y_next >= C_SCREEN_H) begin
                obstacle_y <= 10'd0;
                obstacle_x <= w_spawn_x;
                score      <= (score == 16'hFFFF) ? score : score + 16'd1;
              end else begin
                obstacle_y <= 10'(w_y_next);
              end
            end
          end
        end
        S_OVER: begin
          if (w_start_edge) begin
            r_state         <= S_IDLE;
            game_over       <= 1'b0;
            obstacle_width  <= 10'd0;
            obstacle_height <= 10'd0;
            player_x        <= C_PLAYER_INIT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/game_sequencer.md
# game_sequencer

Frame-rate game controller that owns all object positions consumed by the VGA renderer: player box X, obstacle box X/Y/size, plus score and game-over status. Sits between the synchronized push-button inputs and the combinational renderer. Advances the game once per video frame on a pulse from the VGA timing generator. Runs a three-state IDLE/PLAY/OVER sequencer, clamps player motion, drops and respawns the obstacle using a free-running LFSR, and detects player/obstacle collision.

## Interface
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- BOX_WIDTH, 30, player width
- BOX_HEIGHT, 30, player height
- BOX_Y_START, 315, player top row (fixed)
- PLAYER_X_INIT, 305, player X at reset and on game start
- PLAYER_STEP, 4, pixels moved per frame
- OBS_W, 40, obstacle width while shown
- OBS_H, 20, obstacle height while shown
- OBS_SPEED, 3, obstacle rows fallen per frame
- LFSR_SEED, 10'h1A5, nonzero LFSR reset value

Ports:
- clk  in  1  system clock (pixel clock domain)
- rst  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame, at vertical blanking start
- btn_left  in  1  level, already synchronized, active high
- btn_right  in  1  level, already synchronized, active high
- btn_start  in  1  level, already synchronized, active high
- player_x  out  10  player left edge
- obstacle_x  out  10  obstacle left edge
- obstacle_y  out  10  obstacle top edge
- obstacle_width  out  10  0 in IDLE (obstacle hidden), else OBS_W
- obstacle_height  out  10  0 in IDLE, else OBS_H
- score  out  16  obstacles survived, saturating
- game_over  out  1  high only in OVER
- state  out  2  IDLE=0, PLAY=1, OVER=2

## Operation
- All outputs are registered. Reset values:
  - state=IDLE, player_x=PLAYER_X_INIT
  - obstacle_x=0, obstacle_y=0, width=0, height=0
  - score=0, game_over=0, lfsr=LFSR_SEED
- LFSR:
  - 10-bit Fibonacci, taps x^10+x^7+1.
  - Advances every clk in all states. Never zero.
- Spawn X = (lfsr > SCREEN_W-OBS_W) ? lfsr-(SCREEN_W-OBS_W) : lfsr. Result is always in 0..600.
- Start edge = btn_start high this cycle and low the previous cycle. The previous value is registered and resets to 0.
- IDLE:
  - frame_tick is ignored.
  - On a start edge, go to PLAY and load player_x=PLAYER_X_INIT, obstacle_y=0, obstacle_x=spawn X(current lfsr), width/height=OBS_W/OBS_H, score=0.
- PLAY, on frame_tick:
  1. Collision test on the current registered positions: player_x < obs_x+OBS_W && obs_x < player_x+BOX_WIDTH && BOX_Y_START < obs_y+OBS_H && obs_y < BOX_Y_START+BOX_HEIGHT.
  2. If overlap: go to OVER, set game_over=1, freeze all positions and score. No movement on this tick.
  3. Otherwise, player move:
     - left only: player_x = (player_x < STEP) ? 0 : player_x-STEP
     - right only: player_x = min(player_x+STEP, SCREEN_W-BOX_WIDTH)
     - both or neither: hold
  4. Otherwise, obstacle: y_next = obs_y+OBS_SPEED, computed at 11 bits.
     - If y_next ≥ SCREEN_H: obs_y=0, obs_x=spawn X, score += 1, saturating at 16'hFFFF.
     - Else obs_y=y_next.
- PLAY ignores the start button.
- OVER:
  - Outputs are frozen and frame_tick is ignored.
  - On a start edge: go to IDLE, clear game_over, set width/height=0, reset player_x=PLAYER_X_INIT. Score is held until the next game start.

## Timing
- frame_tick at cycle N: updated outputs are visible at cycle N+1. Single-cycle update, no multicycle paths.
- Start edge at cycle N: state and loaded values are visible at N+1.
- A start edge and frame_tick in the same IDLE cycle: only the transition happens, with no movement.
- frame_tick in the same cycle as the OVER→IDLE start edge: the transition wins.
- A held btn_start produces exactly one transition.
- Reset asserted mid-game: all outputs return to reset values immediately (asynchronous). Operation resumes in IDLE on the first clk edge after release.
- Consecutive frame_tick pulses (back-to-back cycles) are each processed. There are no minimum-spacing assumptions.

## Test plan
- Reset check:
  - Stimulus: assert rst low mid-PLAY with player_x=200.
  - Response: immediately state=0, player_x=305, obstacle_width=0, score=0, game_over=0.
  - After release with no start press: 5 frame_ticks leave all outputs unchanged.
- Right clamp:
  - Stimulus: start, then hold btn_right for 80 frame_ticks (no collision, obstacle placed away).
  - Response: player_x=609 after tick 76, 610 after tick 77, stays 610 through tick 80.
  - Left clamp: holding btn_left from 2 reaches 0 on the next tick. Holding both buttons keeps X unchanged.
- Obstacle drop and respawn:
  - Stimulus: start with the player steered clear, then 160 ticks.
  - Response: obstacle_y=3k after tick k<160. At tick 160, obstacle_y=0, score=1, and obstacle_x is in 0..600 and matches the spawn formula for the sampled lfsr.
- Collision:
  - Stimulus: start, then steer player_x so it overlaps obstacle_x.
  - Response: obstacle_y=297 after tick 99. Tick 100 sets state=2 and game_over=1, with obstacle_y still 297.
  - Further ticks change nothing.
- Start handshake:
  - Stimulus: hold btn_start for 10 cycles in IDLE.
  - Response: exactly one IDLE→PLAY.
  - In OVER, a start edge gives state=0, width/height=0, score held. The next start edge clears score to 0.
- Simultaneous events: start edge coincident with frame_tick in IDLE → state=1, obstacle_y=0, player_x=305 (no move applied).
